e_mdu: RTL and testbench

- Multiply/divide unit in the Execute stage.
- Consumes E-stage operands (rs value on E_O1, rt value on E_O2) and holds the architectural HI/LO registers.
- Executes mult/multu/div/divu as multi-cycle operations with a Busy flag; services mfhi/mflo/mthi/mtlo in a single cycle.
- Its read result is muxed into the E-stage result and forwarded into M_REG; Busy/Start drive the D-stage stall logic.

---
 rtl/e_mdu_if.sv | 27 ++
 rtl/e_mdu.sv | 161 ++++++++++++++++
 tb/tb_e_mdu.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage <-> MDU bundle.
//   master (pipeline) drives Req, Start, MDUOp, E_O1, E_O2
//   slave  (e_mdu)    drives Busy, E_HILO_O, E_HI, E_LO
interface e_mdu_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 4;

  logic            Req;
  logic            Start;
  logic [OP_W-1:0] MDUOp;
  logic [XLEN-1:0] E_O1;
  logic [XLEN-1:0] E_O2;
  logic            Busy;
  logic [XLEN-1:0] E_HILO_O;
  logic [XLEN-1:0] E_HI;
  logic [XLEN-1:0] E_LO;

  modport master (
    output Req, Start, MDUOp, E_O1, E_O2,
    input  Busy, E_HILO_O, E_HI, E_LO
  );

  modport slave (
    input  Req, Start, MDUOp, E_O1, E_O2,
    output Busy, E_HILO_O, E_HI, E_LO
  );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit holding the architectural HI/LO pair.
//   clk, reset (synchronous, active-high)
//   bus (e_mdu_if.slave):
//     Req      flush of the E-stage instruction; blocks Start/mthi/mtlo
//     Start    E-stage instruction is a multi-cycle MDU op
//     MDUOp    0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
//     E_O1/2   rs/rt operands
//     Busy     multi-cycle op in progress
//     E_HILO_O mfhi/mflo read data (combinational)
//     E_HI/LO  current HI/LO
// Optional: define MDU_MADD_EN to add madd(9)/maddu(10)/msub(11)/msubu(12).
// The full result is computed at Start and parked in pending registers; the
// counter only models latency and commits the result when it reaches 1.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DXLEN = 64;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;

  // Datapath results for the op presented this cycle
  logic signed [DXLEN-1:0] a_sx, b_sx;
  logic [DXLEN-1:0]        prod_s, prod_u;
  logic                    sdiv, a_neg, b_neg, div_zero;
  logic [XLEN-1:0]         a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [XLEN-1:0]         res_hi, res_lo;
  logic                    res_wr, start_op, is_div, start_ok;

  // Products: sign- or zero-extend to 64 bits, keep the low 64 of the product
  always_comb begin
    a_sx   = {{XLEN{bus.E_O1[XLEN-1]}}, bus.E_O1};
    b_sx   = {{XLEN{bus.E_O2[XLEN-1]}}, bus.E_O2};
    prod_s = a_sx * b_sx;
    prod_u = {{XLEN{1'b0}}, bus.E_O1} * {{XLEN{1'b0}}, bus.E_O2};
  end

  // Division on magnitudes, then fix signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000/-1 falls out as 0x80000000 r 0.
  always_comb begin
    sdiv     = (bus.MDUOp == 4'd3);
    a_neg    = sdiv & bus.E_O1[XLEN-1];
    b_neg    = sdiv & bus.E_O2[XLEN-1];
    a_mag    = a_neg ? (~bus.E_O1 + 32'd1) : bus.E_O1;
    b_mag    = b_neg ? (~bus.E_O2 + 32'd1) : bus.E_O2;
    div_zero = (bus.E_O2 == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // Op decode and result selection
  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    res_wr   = 1'b1;
    start_op = 1'b0;
    is_div   = 1'b0;
    case (bus.MDUOp)
      4'd1: begin start_op = 1'b1; {res_hi, res_lo} = prod_s; end
      4'd2: begin start_op = 1'b1; {res_hi, res_lo} = prod_u; end
      4'd3, 4'd4: begin
        start_op = 1'b1;
        is_div   = 1'b1;
        res_hi   = rem;
        res_lo   = quot;
        res_wr   = ~div_zero;
      end
`ifdef MDU_MADD_EN
      4'd9:  begin start_op = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} + prod_s; end
      4'd10: begin start_op = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} + prod_u; end
      4'd11: begin start_op = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} - prod_s; end
      4'd12: begin start_op = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} - prod_u; end
`endif
      default: ;
    endcase
  end

  assign start_ok = (state_q == S_IDLE) & bus.Start & ~bus.Req & start_op;

  // Next-state: start, countdown/commit, mthi/mtlo when idle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d   = S_RUN;
          cnt_d     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_wr_d = res_wr;
        end else if (!bus.Req && bus.MDUOp == 4'd7) begin
          hi_d = bus.E_O1;
        end else if (!bus.Req && bus.MDUOp == 4'd8) begin
          lo_d = bus.E_O1;
        end
      end
      S_RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Outputs
  assign bus.Busy     = (state_q == S_RUN);
  assign bus.E_HI     = hi_q;
  assign bus.E_LO     = lo_q;
  assign bus.E_HILO_O = (bus.MDUOp == 4'd5) ? hi_q :
                        (bus.MDUOp == 4'd6) ? lo_q : '0;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: table vectors, hand-written corner sequences and random ops
// against an arithmetic reference model of HI/LO.
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_mdu_if bus();
  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[10];
  logic [31:0] m_hi, m_lo, n_hi, n_lo;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return MC;
      4'd3, 4'd4: return DC;
`ifdef MDU_MADD_EN
      4'd9, 4'd10, 4'd11, 4'd12: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural rules
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] o_hi, output logic [31:0] o_lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, acc, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    acc = {hi, lo};
    o_hi = hi;
    o_lo = lo;
    case (op)
      4'd1: begin p = longint'(sa * sb); o_hi = p[63:32]; o_lo = p[31:0]; end
      4'd2: begin p = ua * ub; o_hi = p[63:32]; o_lo = p[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; o_hi = r[31:0]; o_lo = q[31:0]; end
      4'd4: if (b != 0) begin p = ua / ub; acc = ua % ub; o_hi = acc[31:0]; o_lo = p[31:0]; end
      4'd9:  begin p = acc + longint'(sa * sb); o_hi = p[63:32]; o_lo = p[31:0]; end
      4'd10: begin p = acc + ua * ub;           o_hi = p[63:32]; o_lo = p[31:0]; end
      4'd11: begin p = acc - longint'(sa * sb); o_hi = p[63:32]; o_lo = p[31:0]; end
      4'd12: begin p = acc - ua * ub;           o_hi = p[63:32]; o_lo = p[31:0]; end
      default: ;
    endcase
  endfunction

  task automatic idle_in();
    bus.Start = 1'b0;
    bus.MDUOp = 4'd0;
    bus.Req   = 1'b0;
    bus.E_O1  = 32'd0;
    bus.E_O2  = 32'd0;
  endtask

  // Issue one op and count the cycles Busy is observed high
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = op; bus.E_O1 = a; bus.E_O2 = b; bus.Req = 1'b0;
    @(negedge clk);
    idle_in();
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    run_op(op, a, b, n);
    chk({name, "_busy_cycles"}, 64'(n), 64'(exp_cycles(op)));
    chk({name, "_hi"}, 64'(bus.E_HI), 64'(ehi));
    chk({name, "_lo"}, 64'(bus.E_LO), 64'(elo));
  endtask

  task automatic read_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    bus.MDUOp = 4'd5; #1;
    chk({name, "_mfhi"}, 64'(bus.E_HILO_O), 64'(ehi));
    bus.MDUOp = 4'd6; #1;
    chk({name, "_mflo"}, 64'(bus.E_HILO_O), 64'(elo));
    bus.MDUOp = 4'd0; #1;
    chk({name, "_none"}, 64'(bus.E_HILO_O), 64'd0);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    bus.MDUOp = op; bus.E_O1 = v;
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] op;
    logic [31:0] a, b;
    tbl[0] = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{4'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{4'd4, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[6] = '{4'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    tbl[7] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[8] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[9] = '{4'd3, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};

    // Reset state
    idle_in();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 64'(bus.Busy), 64'd0);
    chk("reset_hi", 64'(bus.E_HI), 64'd0);
    chk("reset_lo", 64'(bus.E_LO), 64'd0);
    read_hilo("reset", 32'd0, 32'd0);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
      if (i == 0 || i == 7) read_hilo($sformatf("vec%0d", i), tbl[i].hi, tbl[i].lo);
    end

    // mthi blocked by Req, then accepted
    @(negedge clk);
    bus.MDUOp = 4'd7; bus.E_O1 = 32'h12345678; bus.Req = 1'b1;
    @(negedge clk);
    chk("mthi_req_hi", 64'(bus.E_HI), 64'd0);
    bus.Req = 1'b0;
    @(negedge clk);
    idle_in();
    chk("mthi_hi", 64'(bus.E_HI), 64'h12345678);
    mt(4'd8, 32'hCAFEF00D);
    chk("mtlo_lo", 64'(bus.E_LO), 64'hCAFEF00D);

    // Req raised during RUN does not cancel the op
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = 4'd1; bus.E_O1 = 32'd3; bus.E_O2 = 32'd4;
    @(negedge clk);
    idle_in();
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      bus.Req = (n == 2 || n == 3);
      @(negedge clk);
    end
    bus.Req = 1'b0;
    chk("req_run_cycles", 64'(n), 64'(MC));
    chk("req_run_hi", 64'(bus.E_HI), 64'd0);
    chk("req_run_lo", 64'(bus.E_LO), 64'd12);

    // Start(divu) and mtlo while busy are ignored
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = 4'd1; bus.E_O1 = 32'd6; bus.E_O2 = 32'd7;
    @(negedge clk);
    idle_in();
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      idle_in();
      if (n == 2) begin
        bus.Start = 1'b1; bus.MDUOp = 4'd4; bus.E_O1 = 32'd99; bus.E_O2 = 32'd5;
      end else if (n == 3) begin
        bus.MDUOp = 4'd8; bus.E_O1 = 32'hDEAD;
      end
      @(negedge clk);
    end
    idle_in();
    chk("busy_ign_cycles", 64'(n), 64'(MC));
    chk("busy_ign_hi", 64'(bus.E_HI), 64'd0);
    chk("busy_ign_lo", 64'(bus.E_LO), 64'd42);
    @(negedge clk);
    chk("busy_ign_idle", 64'(bus.Busy), 64'd0);

    // Reset in the middle of a run
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = 4'd1; bus.E_O1 = 32'd2; bus.E_O2 = 32'd3;
    @(negedge clk);
    idle_in();
    n = 1;
    while (bus.Busy && n < 3) begin
      n++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_run_busy", 64'(bus.Busy), 64'd0);
    chk("rst_run_hi", 64'(bus.E_HI), 64'd0);
    chk("rst_run_lo", 64'(bus.E_LO), 64'd0);
    repeat (MC) @(negedge clk);
    chk("rst_run_lo_later", 64'(bus.E_LO), 64'd0);

    // Start with a non-MDU op has no effect
    mt(4'd8, 32'h55);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = 4'd5;
    @(negedge clk);
    idle_in();
    chk("bad_op_busy", 64'(bus.Busy), 64'd0);
    chk("bad_op_lo", 64'(bus.E_LO), 64'h55);

    // Accumulate op: macro build updates, default build treats it as a no-op
    mt(4'd7, 32'h0);
    mt(4'd8, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    check_op("maddu", 4'd10, 32'd1, 32'd1, 32'd1, 32'd0);
    m_hi = 32'd1; m_lo = 32'd0;
`else
    check_op("maddu_off", 4'd10, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF);
    m_hi = 32'd0; m_lo = 32'hFFFFFFFF;
`endif

    // Random ops against the model
    for (int i = 0; i < 24; i++) begin
`ifdef MDU_MADD_EN
      n = int'($urandom_range(0, 7));
      op = (n < 4) ? 4'(n + 1) : 4'(n + 5);
`else
      op = 4'($urandom_range(1, 4));
`endif
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model(op, a, b, m_hi, m_lo, n_hi, n_lo);
      check_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, n_hi, n_lo);
      m_hi = n_hi;
      m_lo = n_lo;
    end
    read_hilo("rnd_end", m_hi, m_lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
